// File: rtl/ct_spsram_param_init.sv
// Parametrised single-port SRAM wrapper with optional output register and a
// post-reset zeroize engine that clears every entry before accepting accesses.
module ct_spsram_param_init #(
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 144,
    parameter int unsigned WE_GRAN    = 1,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned INIT_EN    = 1
) (
    input  logic                             CLK,
    input  logic                             cpurst_b,
    input  logic                             CEN,
    input  logic                             GWEN,
    input  logic [DATA_WIDTH/WE_GRAN-1:0]    WEN,
    input  logic [ADDR_WIDTH-1:0]            A,
    input  logic [DATA_WIDTH-1:0]            D,
    output logic [DATA_WIDTH-1:0]            Q,
    output logic                             Q_VLD,
    output logic                             INIT_BUSY
);

    localparam int unsigned            NUM_SLICES = DATA_WIDTH / WE_GRAN;
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic                   RST_BUSY   = (INIT_EN != 0);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = (INIT_EN != 0) ? CLEAR : READY;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic                    init_busy_q, init_busy_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_vld_q, rd_vld_d;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NUM_SLICES-1:0]   mem_wmask;
    logic                    rd_en;
    logic                    addr_ok;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign addr_ok = (32'(A) < DEPTH);

    // Next-state, write-port steering and read capture
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        init_busy_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = A;
        mem_wdata   = D;
        mem_wmask   = ~WEN;
        rd_en       = 1'b0;

        unique case (state_q)
            CLEAR: begin
                mem_we      = 1'b1;
                mem_waddr   = clr_addr_q;
                mem_wdata   = '0;
                mem_wmask   = '1;
                init_busy_d = 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d     = READY;
                    clr_addr_d  = '0;
                    init_busy_d = 1'b0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                end
            end
            READY: begin
                if (!CEN) begin
                    if (!GWEN) begin
                        mem_we = addr_ok;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
        endcase

        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = addr_ok ? mem[A] : '0;
        end
        rd_vld_d = rd_en;
    end

    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= RST_STATE;
            clr_addr_q  <= '0;
            init_busy_q <= RST_BUSY;
            rd_data_q   <= '0;
            rd_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_busy_q <= init_busy_d;
            rd_data_q   <= rd_data_d;
            rd_vld_q    <= rd_vld_d;
        end
    end

    // Storage has no reset so it maps onto a RAM macro
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int k = 0; k < NUM_SLICES; k++) begin
                if (mem_wmask[k]) begin
                    mem[mem_waddr][k*WE_GRAN +: WE_GRAN] <= mem_wdata[k*WE_GRAN +: WE_GRAN];
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q_q, q_d;
        logic                  q_vld_q, q_vld_d;

        always_comb begin
            q_d     = rd_vld_q ? rd_data_q : q_q;
            q_vld_d = rd_vld_q;
        end

        always_ff @(posedge CLK or negedge cpurst_b) begin
            if (!cpurst_b) begin
                q_q     <= '0;
                q_vld_q <= 1'b0;
            end else begin
                q_q     <= q_d;
                q_vld_q <= q_vld_d;
            end
        end

        assign Q     = q_q;
        assign Q_VLD = q_vld_q;
    end else begin : g_out_direct
        assign Q     = rd_data_q;
        assign Q_VLD = rd_vld_q;
    end

    assign INIT_BUSY = init_busy_q;

endmodule

// File: tb/tb_ct_spsram_param_init.sv
// Scoreboard bench: two instances (DEPTH=100/byte mask/2-cycle read and
// DEPTH=128/bit mask/1-cycle read) share stimulus and are checked against array models.
module tb_ct_spsram_param_init;

    localparam int unsigned DW = 144;
    localparam int unsigned AW = 7;
    localparam int unsigned D0 = 100;
    localparam int unsigned D1 = 128;
    localparam int unsigned S0 = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cen, gwen;
    logic [S0-1:0] wen0;
    logic [DW-1:0] wen1;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] q_dut0, q_dut1;
    logic          vld0, vld1, busy0, busy1;

    int unsigned   cyc = 0;
    int unsigned   rel_cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    logic [DW-1:0] mem0 [D1];
    logic [DW-1:0] mem1 [D1];
    exp_t          sb0[$];
    exp_t          sb1[$];
    exp_t          e0, e1;
    logic [DW-1:0] last0, last1;

    ct_spsram_param_init #(
        .DEPTH(D0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_GRAN(8), .OUT_REG(1), .INIT_EN(1)
    ) dut0 (
        .CLK(clk), .cpurst_b(rst_n), .CEN(cen), .GWEN(gwen), .WEN(wen0),
        .A(a), .D(d), .Q(q_dut0), .Q_VLD(vld0), .INIT_BUSY(busy0)
    );

    ct_spsram_param_init #(
        .DEPTH(D1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_GRAN(1), .OUT_REG(0), .INIT_EN(1)
    ) dut1 (
        .CLK(clk), .cpurst_b(rst_n), .CEN(cen), .GWEN(gwen), .WEN(wen1),
        .A(a), .D(d), .Q(q_dut1), .Q_VLD(vld1), .INIT_BUSY(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rel_cyc <= 0;
        else        rel_cyc <= rel_cyc + 1;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // Monitor for the DEPTH=100, two-cycle instance
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_q0", q_dut0, '0);
            chk("rst_vld0", DW'(vld0), '0);
            chk("rst_busy0", DW'(busy0), DW'(1));
        end else begin
            chk("busy0", DW'(busy0), DW'(rel_cyc < D0));
            if (vld0) begin
                if (sb0.size() == 0) begin
                    chk("spurious_vld0", DW'(vld0), '0);
                end else begin
                    e0 = sb0.pop_front();
                    chk("rdata0", q_dut0, e0.data);
                    chk("latency0", DW'(cyc), DW'(e0.cyc));
                    last0 = e0.data;
                end
            end else begin
                chk("hold0", q_dut0, last0);
                if (sb0.size() != 0 && sb0[0].cyc <= cyc) begin
                    e0 = sb0.pop_front();
                    chk("missing_vld0", DW'(vld0), DW'(1));
                end
            end
        end
    end

    // Monitor for the DEPTH=128, one-cycle instance
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_q1", q_dut1, '0);
            chk("rst_vld1", DW'(vld1), '0);
            chk("rst_busy1", DW'(busy1), DW'(1));
        end else begin
            chk("busy1", DW'(busy1), DW'(rel_cyc < D1));
            if (vld1) begin
                if (sb1.size() == 0) begin
                    chk("spurious_vld1", DW'(vld1), '0);
                end else begin
                    e1 = sb1.pop_front();
                    chk("rdata1", q_dut1, e1.data);
                    chk("latency1", DW'(cyc), DW'(e1.cyc));
                    last1 = e1.data;
                end
            end else begin
                chk("hold1", q_dut1, last1);
                if (sb1.size() != 0 && sb1[0].cyc <= cyc) begin
                    e1 = sb1.pop_front();
                    chk("missing_vld1", DW'(vld1), DW'(1));
                end
            end
        end
    end

    // Reference: an access only counts once the instance has had DEPTH clear cycles
    task automatic apply_ops(input logic c, input logic g, input logic [S0-1:0] w0,
                             input logic [DW-1:0] w1, input logic [AW-1:0] adr,
                             input logic [DW-1:0] dat);
        logic [DW-1:0] v;
        if (rst_n && !c) begin
            if (rel_cyc >= D0) begin
                if (!g) begin
                    if (adr < D0)
                        for (int k = 0; k < S0; k++)
                            if (!w0[k]) mem0[adr][k*8 +: 8] = dat[k*8 +: 8];
                end else begin
                    v = (adr < D0) ? mem0[adr] : '0;
                    sb0.push_back('{v, cyc + 2});
                end
            end
            if (rel_cyc >= D1) begin
                if (!g) mem1[adr] = (mem1[adr] & w1) | (dat & ~w1);
                else    sb1.push_back('{mem1[adr], cyc + 1});
            end
        end
    endtask

    task automatic step(input logic c, input logic g, input logic [S0-1:0] w0,
                        input logic [DW-1:0] w1, input logic [AW-1:0] adr,
                        input logic [DW-1:0] dat);
        cen = c; gwen = g; wen0 = w0; wen1 = w1; a = adr; d = dat;
        apply_ops(c, g, w0, w1, adr, dat);
        @(negedge clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] adr);
        step(1'b0, 1'b1, S0'($urandom), rnd(), adr, rnd());
    endtask

    task automatic wr(input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      input logic [S0-1:0] w0, input logic [DW-1:0] w1);
        step(1'b0, 1'b0, w0, w1, adr, dat);
    endtask

    task automatic idle();
        step(1'b1, 1'($urandom), S0'($urandom), rnd(), AW'($urandom), rnd());
    endtask

    task automatic junk();
        step(1'($urandom), 1'($urandom), S0'($urandom), rnd(), AW'($urandom), rnd());
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        cen   = 1'b1;
        sb0.delete();
        sb1.delete();
        last0 = '0;
        last1 = '0;
        for (int i = 0; i < D1; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        repeat (n) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic busy_phase();
        repeat (D0) junk();
        repeat (D1 - D0) idle();
    endtask

    initial begin
        rst_n = 1'b1;
        cen = 1'b1; gwen = 1'b1; wen0 = '1; wen1 = '1; a = '0; d = '0;
        last0 = '0; last1 = '0;
        #1;
        do_reset(3);

        // Accesses during clear are ignored
        repeat (D0) wr(AW'(10), '1, '0, '0);
        repeat (D1 - D0) idle();
        for (int i = 0; i < 128; i++) rd(AW'(i));

        wr(AW'(5), {9{16'hA5A5}}, '0, '0);
        rd(AW'(5));

        wr(AW'(3), '1, '0, '0);
        wr(AW'(3), '0, S0'('h3FFFE), {{(DW-8){1'b1}}, 8'h00});
        rd(AW'(3));

        wr(AW'(110), rnd(), '0, '0);
        rd(AW'(110));
        for (int i = 0; i < 128; i++) rd(AW'(i));

        wr(AW'(7), rnd(), '0, '0);
        rd(AW'(7));
        repeat (10) idle();

        repeat (600) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom),
                 ($urandom_range(0, 2) == 0) ? '0 : S0'($urandom),
                 ($urandom_range(0, 2) == 0) ? '0 : rnd(),
                 AW'($urandom_range(0, 127)), rnd());
        end

        // Reset in READY with a read still in flight
        wr(AW'(20), rnd(), '0, '0);
        rd(AW'(20));
        do_reset(2);

        // Reset again in the middle of clearing
        repeat (60) junk();
        do_reset(2);
        busy_phase();
        for (int i = 0; i < 128; i++) rd(AW'(i));

        repeat (4) idle();
        chk("drain0", DW'(sb0.size()), '0);
        chk("drain1", DW'(sb1.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
